// File: rtl/mem_access_unit_if.sv
// Request, write-back and data-memory signals of mem_access_unit.
// Port suffixes (_i/_o) are named from the unit's point of view.
interface mem_access_unit_if #(
   parameter int AW = 32,
   parameter int DW = 32
) ();
   logic          req_valid_i;
   logic          req_ready_o;
   logic          req_we_i;
   logic [1:0]    req_size_i;
   logic          req_signed_i;
   logic [AW-1:0] req_addr_i;
   logic [DW-1:0] req_wdata_i;
   logic [4:0]    req_rd_i;

   logic          wb_valid_o;
   logic [DW-1:0] wb_data_o;
   logic [4:0]    wb_rd_o;
   logic          st_done_o;
   logic          err_o;

   logic          dm_ren_o;
   logic          dm_wen_o;
   logic [AW-1:0] dm_addr_o;
   logic [DW-1:0] dm_wdata_o;
   logic [DW-1:0] dm_rdata_i;

   modport slave (
      input  req_valid_i, req_we_i, req_size_i, req_signed_i,
             req_addr_i, req_wdata_i, req_rd_i, dm_rdata_i,
      output req_ready_o, wb_valid_o, wb_data_o, wb_rd_o,
             st_done_o, err_o, dm_ren_o, dm_wen_o, dm_addr_o, dm_wdata_o
   );

   modport master (
      output req_valid_i, req_we_i, req_size_i, req_signed_i,
             req_addr_i, req_wdata_i, req_rd_i, dm_rdata_i,
      input  req_ready_o, wb_valid_o, wb_data_o, wb_rd_o,
             st_done_o, err_o, dm_ren_o, dm_wen_o, dm_addr_o, dm_wdata_o
   );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store stage in front of a word-wide data memory: byte-to-word address
// conversion, read-modify-write for sub-word stores, aligned/extended loads.
module mem_access_unit #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   mem_access_unit_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LD     = 3'd1,
      S_ST     = 3'd2,
      S_RMW_RD = 3'd3,
      S_RMW_WR = 3'd4,
      S_ERR    = 3'd5
   } state_e;

   state_e        state_q, state_d;
   logic          we_q;
   logic [1:0]    size_q;
   logic          signed_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [4:0]    rd_q;
   logic [DW-1:0] merge_q, merge_d;
   logic [DW-1:0] dm_wdata_q, dm_wdata_d;
   logic          wb_valid_q;
   logic [DW-1:0] wb_data_q;
   logic [4:0]    wb_rd_q;
   logic          st_done_q;
   logic          err_q;
   logic          accept_s;
   logic [1:0]    lane_s;

   function automatic logic misaligned_f(input logic [1:0] size, input logic [1:0] a);
      logic m;
      case (size)
         2'b00:   m = 1'b0;
         2'b01:   m = a[0];
         2'b10:   m = (a != 2'b00);
         default: m = 1'b1;
      endcase
      return m;
   endfunction

   function automatic logic [DW-1:0] load_extract_f(input logic [DW-1:0] word,
                                                    input logic [1:0]    size,
                                                    input logic [1:0]    lane,
                                                    input logic          sgn);
      logic [7:0]    b;
      logic [15:0]   h;
      logic [DW-1:0] r;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         2'd3:    b = word[31:24];
         default: b = word[7:0];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         2'b00:   r = {{24{sgn & b[7]}}, b};
         2'b01:   r = {{16{sgn & h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   function automatic logic [DW-1:0] store_merge_f(input logic [DW-1:0] old,
                                                   input logic [DW-1:0] wd,
                                                   input logic [1:0]    size,
                                                   input logic [1:0]    lane);
      logic [DW-1:0] r;
      r = old;
      case (size)
         2'b00: begin
            case (lane)
               2'd0:    r[7:0]   = wd[7:0];
               2'd1:    r[15:8]  = wd[7:0];
               2'd2:    r[23:16] = wd[7:0];
               2'd3:    r[31:24] = wd[7:0];
               default: r[7:0]   = wd[7:0];
            endcase
         end
         2'b01: begin
            if (lane[1]) begin
               r[31:16] = wd[15:0];
            end else begin
               r[15:0] = wd[15:0];
            end
         end
         default: r = wd;
      endcase
      return r;
   endfunction

   assign accept_s = bus.req_valid_i & (state_q == S_IDLE);
   assign lane_s   = addr_q[1:0];

   // Next-state decode; the request fields are only looked at in IDLE.
   always_comb begin
      state_d = state_q;
      merge_d = merge_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               if (misaligned_f(bus.req_size_i, bus.req_addr_i[1:0])) begin
                  state_d = S_ERR;
               end else if (!bus.req_we_i) begin
                  state_d = S_LD;
               end else if (bus.req_size_i == 2'b10) begin
                  state_d = S_ST;
               end else begin
                  state_d = S_RMW_RD;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LD:     state_d = S_IDLE;
         S_ST:     state_d = S_IDLE;
         S_RMW_RD: begin
            merge_d = bus.dm_rdata_i;
            state_d = S_RMW_WR;
         end
         S_RMW_WR: state_d = S_IDLE;
         S_ERR:    state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Write data is live in the two write states and otherwise holds its last value.
   always_comb begin
      case (state_q)
         S_ST:     dm_wdata_d = wdata_q;
         S_RMW_WR: dm_wdata_d = store_merge_f(merge_q, wdata_q, size_q, lane_s);
         default:  dm_wdata_d = dm_wdata_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         merge_q    <= '0;
         dm_wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         merge_q    <= merge_d;
         dm_wdata_q <= dm_wdata_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         we_q     <= 1'b0;
         size_q   <= 2'b00;
         signed_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rd_q     <= 5'd0;
      end else if (accept_s) begin
         we_q     <= bus.req_we_i;
         size_q   <= bus.req_size_i;
         signed_q <= bus.req_signed_i;
         addr_q   <= bus.req_addr_i;
         wdata_q  <= bus.req_wdata_i;
         rd_q     <= bus.req_rd_i;
      end
   end

   // Completion pulses trail the producing state by one cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wb_valid_q <= 1'b0;
         wb_data_q  <= '0;
         wb_rd_q    <= 5'd0;
         st_done_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         wb_valid_q <= (state_q == S_LD);
         st_done_q  <= (state_q == S_ST) || (state_q == S_RMW_WR);
         err_q      <= (state_q == S_ERR);
         if (state_q == S_LD) begin
            wb_data_q <= load_extract_f(bus.dm_rdata_i, size_q, lane_s, signed_q);
            wb_rd_q   <= rd_q;
         end
      end
   end

   // Enables are masked by reset so the memory is never touched while rst_i is high.
   assign bus.dm_ren_o    = ~rst_i & ((state_q == S_LD) || (state_q == S_RMW_RD));
   assign bus.dm_wen_o    = ~rst_i & we_q & ((state_q == S_ST) || (state_q == S_RMW_WR));
   assign bus.dm_addr_o   = {2'b00, addr_q[AW-1:2]};
   assign bus.dm_wdata_o  = dm_wdata_d;
   assign bus.req_ready_o = (state_q == S_IDLE);
   assign bus.wb_valid_o  = wb_valid_q;
   assign bus.wb_data_o   = wb_data_q;
   assign bus.wb_rd_o     = wb_rd_q;
   assign bus.st_done_o   = st_done_q;
   assign bus.err_o       = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus random bench for mem_access_unit against an arithmetic
// reference model of a 64-word little-endian memory.
module tb_mem_access_unit;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MW = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_init;
   logic [31:0] mem     [0:MW-1];
   logic [31:0] ref_mem [0:MW-1];
   int          n_checks = 0;
   int          n_fail   = 0;

   mem_access_unit_if #(.AW(AW), .DW(DW)) bus ();

   mem_access_unit #(.AW(AW), .DW(DW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] seed_word(input int i);
      if (i == 16) return 32'h8899_AABB;
      return 32'h1357_9BDF ^ (i * 32'h0102_0408);
   endfunction

   assign bus.dm_rdata_i = mem[bus.dm_addr_o[5:0]];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < MW; i++) mem[i] <= seed_word(i);
      end else if (bus.dm_wen_o) begin
         mem[bus.dm_addr_o[5:0]] <= bus.dm_wdata_o;
      end
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic ctl(input string tag, input logic rdy, input logic ren, input logic wen,
                      input logic wbv, input logic std, input logic er);
      chk1({tag, ".req_ready"}, bus.req_ready_o, rdy);
      chk1({tag, ".dm_ren"},    bus.dm_ren_o,    ren);
      chk1({tag, ".dm_wen"},    bus.dm_wen_o,    wen);
      chk1({tag, ".wb_valid"},  bus.wb_valid_o,  wbv);
      chk1({tag, ".st_done"},   bus.st_done_o,   std);
      chk1({tag, ".err"},       bus.err_o,       er);
   endtask

   // Called at a negedge with the unit idle; returns at the negedge of its last cycle.
   task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                         input logic sgn, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
      int          wa;
      int          shift;
      logic        mis;
      logic [31:0] raw, ld_v, mask, new_w;
      wa    = int'(addr >> 2);
      shift = int'(addr % 32'd4) * 8;
      mis   = (size == 2'd3) || (size == 2'd1 && addr % 32'd2 != 32'd0) ||
              (size == 2'd2 && addr % 32'd4 != 32'd0);
      raw   = ref_mem[wa] >> shift;
      if (size == 2'd0) begin
         ld_v = raw & 32'h0000_00FF;
         if (sgn && ld_v >= 32'd128) ld_v = ld_v - 32'd256;
         mask = 32'h0000_00FF << shift;
      end else if (size == 2'd1) begin
         ld_v = raw & 32'h0000_FFFF;
         if (sgn && ld_v >= 32'h0000_8000) ld_v = ld_v - 32'h0001_0000;
         mask = 32'h0000_FFFF << shift;
      end else begin
         ld_v = raw;
         mask = 32'hFFFF_FFFF;
      end
      new_w = (ref_mem[wa] & ~mask) | ((wdata << shift) & mask);

      chk1({tag, ".ready_in"}, bus.req_ready_o, 1'b1);
      bus.req_valid_i  = 1'b1;
      bus.req_we_i     = we;
      bus.req_size_i   = size;
      bus.req_signed_i = sgn;
      bus.req_addr_i   = addr;
      bus.req_wdata_i  = wdata;
      bus.req_rd_i     = rd;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid_i  = 1'b0;
      bus.req_we_i     = ~we;
      bus.req_size_i   = 2'($urandom);
      bus.req_signed_i = ~sgn;
      bus.req_addr_i   = $urandom;
      bus.req_wdata_i  = $urandom;
      bus.req_rd_i     = 5'($urandom);

      if (mis) begin
         ctl({tag, ".c1"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         @(negedge clk);
         ctl({tag, ".c2"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end else if (!we) begin
         ctl({tag, ".c1"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         chk32({tag, ".dm_addr"}, bus.dm_addr_o, addr >> 2);
         @(negedge clk);
         ctl({tag, ".c2"}, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         chk32({tag, ".wb_data"}, bus.wb_data_o, ld_v);
         chk32({tag, ".wb_rd"}, {27'd0, bus.wb_rd_o}, {27'd0, rd});
      end else if (size == 2'd2) begin
         ctl({tag, ".c1"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         chk32({tag, ".dm_addr"}, bus.dm_addr_o, addr >> 2);
         chk32({tag, ".dm_wdata"}, bus.dm_wdata_o, new_w);
         @(negedge clk);
         ctl({tag, ".c2"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         ref_mem[wa] = new_w;
      end else begin
         ctl({tag, ".c1"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         chk32({tag, ".rd_addr"}, bus.dm_addr_o, addr >> 2);
         @(negedge clk);
         ctl({tag, ".c2"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         chk32({tag, ".wr_addr"}, bus.dm_addr_o, addr >> 2);
         chk32({tag, ".dm_wdata"}, bus.dm_wdata_o, new_w);
         @(negedge clk);
         ctl({tag, ".c3"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         ref_mem[wa] = new_w;
      end
   endtask

   initial begin
      rst              = 1'b1;
      mem_init         = 1'b1;
      bus.req_valid_i  = 1'b0;
      bus.req_we_i     = 1'b0;
      bus.req_size_i   = 2'b00;
      bus.req_signed_i = 1'b0;
      bus.req_addr_i   = 32'd0;
      bus.req_wdata_i  = 32'd0;
      bus.req_rd_i     = 5'd0;
      for (int i = 0; i < MW; i++) ref_mem[i] = seed_word(i);
      repeat (2) @(posedge clk);
      @(negedge clk);

      ctl("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk32("reset.dm_addr",  bus.dm_addr_o,  32'd0);
      chk32("reset.dm_wdata", bus.dm_wdata_o, 32'd0);
      chk32("reset.wb_data",  bus.wb_data_o,  32'd0);
      chk32("reset.wb_rd",    {27'd0, bus.wb_rd_o}, 32'd0);
      mem_init = 1'b0;
      rst      = 1'b0;
      @(negedge clk);

      do_req("ld_sb_41",   1'b0, 2'd0, 1'b1, 32'h41, 32'h0,        5'd5);
      chk32("ld_sb_41.value", bus.wb_data_o, 32'hFFFF_FFAA);
      do_req("ld_uh_40",   1'b0, 2'd1, 1'b0, 32'h40, 32'h0,        5'd6);
      chk32("ld_uh_40.value", bus.wb_data_o, 32'h0000_AABB);
      do_req("ld_sh_42",   1'b0, 2'd1, 1'b1, 32'h42, 32'h0,        5'd7);
      chk32("ld_sh_42.value", bus.wb_data_o, 32'hFFFF_8899);
      do_req("st_h_42",    1'b1, 2'd1, 1'b0, 32'h42, 32'hFFFF_1234, 5'd0);
      do_req("st_b_40",    1'b1, 2'd0, 1'b0, 32'h40, 32'h0000_005A, 5'd0);
      do_req("ld_w_40",    1'b0, 2'd2, 1'b0, 32'h40, 32'h0,        5'd8);
      chk32("ld_w_40.value", bus.wb_data_o, 32'h1234_AA5A);
      do_req("st_w_44",    1'b1, 2'd2, 1'b0, 32'h44, 32'hDEAD_BEEF, 5'd0);
      do_req("ld_w_44",    1'b0, 2'd2, 1'b0, 32'h44, 32'h0,        5'd9);
      chk32("ld_w_44.value", bus.wb_data_o, 32'hDEAD_BEEF);
      do_req("err_ldw_43", 1'b0, 2'd2, 1'b0, 32'h43, 32'h0,        5'd10);
      do_req("err_sth_45", 1'b1, 2'd1, 1'b0, 32'h45, 32'h0000_7777, 5'd0);
      do_req("err_rsv_48", 1'b0, 2'd3, 1'b0, 32'h48, 32'h0,        5'd11);

      // Reset while the read half of a byte store is in flight.
      bus.req_valid_i  = 1'b1;
      bus.req_we_i     = 1'b1;
      bus.req_size_i   = 2'd0;
      bus.req_addr_i   = 32'h49;
      bus.req_wdata_i  = 32'h0000_00C3;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      ctl("rst_rmw.c1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      chk1("rst_rmw.ren_in_rst", bus.dm_ren_o, 1'b0);
      chk1("rst_rmw.wen_in_rst", bus.dm_wen_o, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      ctl("rst_rmw.after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         ctl($sformatf("rst_rmw.idle%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      do_req("rst_rmw.ld", 1'b0, 2'd2, 1'b0, 32'h48, 32'h0, 5'd12);

      // Reset while a load is in its memory-read cycle: no write-back pulse.
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = 1'b0;
      bus.req_size_i  = 2'd2;
      bus.req_addr_i  = 32'h10;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      ctl("rst_ld.after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      ctl("rst_ld.idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 120; i++) begin
         do_req($sformatf("rnd%0d", i), 1'($urandom), 2'($urandom), 1'($urandom),
                {24'd0, 8'($urandom)}, $urandom, 5'($urandom));
      end

      for (int i = 0; i < MW; i++) begin
         chk32($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
